csi2_tx_rawn_packer: RTL and testbench

Generalised successor to the RAW16-only byte serialiser in the CSI-2 TX path. It accepts right-justified pixels on a 16-bit AXI4-Stream and emits a CSI-2 RAW8, RAW10, RAW12 or RAW16 byte stream toward the packetizer. The mode is runtime-selectable per frame. The block adds buffered output, so input stalls occur only when the buffer lacks space, and it checks line length.

---
 rtl/csi2_tx_pkg.sv | 43 ++++
 rtl/csi2_tx_byte_fifo.sv | 63 ++++++
 rtl/csi2_tx_rawn_packer.sv | 192 +++++++++++++++++++
 tb/tb_csi2_tx_rawn_packer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2_tx_pkg.sv
// Shared types and pixel-group geometry for the CSI-2 TX RAWn byte packer.
package csi2_tx_pkg;

  typedef enum logic [1:0] {
    RAW8  = 2'd0,
    RAW10 = 2'd1,
    RAW12 = 2'd2,
    RAW16 = 2'd3
  } raw_mode_t;

  localparam int unsigned MAX_GRP_BYTES = 5;

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } buf_ent_t;

  function automatic logic [2:0] grp_pixels(input raw_mode_t mode);
    logic [2:0] n;
    case (mode)
      RAW8:    n = 3'd1;
      RAW10:   n = 3'd4;
      RAW12:   n = 3'd2;
      RAW16:   n = 3'd1;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] grp_bytes(input raw_mode_t mode);
    logic [2:0] n;
    case (mode)
      RAW8:    n = 3'd1;
      RAW10:   n = 3'd5;
      RAW12:   n = 3'd3;
      RAW16:   n = 3'd2;
      default: n = 3'd2;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/csi2_tx_byte_fifo.sv
// Shift-register byte buffer: entry 0 is always the head, so the output is a plain register.
// Accepts up to MAX_GRP_BYTES pushes and one pop per cycle.
module csi2_tx_byte_fifo
  import csi2_tx_pkg::*;
#(
  parameter int unsigned BUF_BYTES = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [2:0]                         push_n_i,
  input  buf_ent_t [MAX_GRP_BYTES-1:0]       push_ent_i,
  input  logic                               pop_i,
  output logic [$clog2(BUF_BYTES+1)-1:0]     count_o,
  output logic [$clog2(BUF_BYTES+1)-1:0]     count_nxt_o,
  output buf_ent_t                           head_o
);

  localparam int unsigned CNT_W = $clog2(BUF_BYTES + 1);

  buf_ent_t [BUF_BYTES-1:0] ent_q;
  buf_ent_t [BUF_BYTES-1:0] ent_d;
  buf_ent_t [BUF_BYTES-1:0] shift_s;
  logic [CNT_W-1:0]         count_q;
  logic [CNT_W-1:0]         count_d;
  logic                     pop_s;
  int                       base_s;

  assign pop_s = pop_i && (count_q != '0);

  // Shift out the popped head (zero-filling the tail), then append pushed bytes.
  always_comb begin
    if (pop_s) begin
      shift_s = {buf_ent_t'('0), ent_q[BUF_BYTES-1:1]};
      base_s  = int'(count_q) - 1;
    end else begin
      shift_s = ent_q;
      base_s  = int'(count_q);
    end
    for (int i = 0; i < int'(BUF_BYTES); i++) begin
      ent_d[i] = shift_s[i];
      for (int j = 0; j < int'(MAX_GRP_BYTES); j++) begin
        ent_d[i] = ((j < int'(push_n_i)) && (i == base_s + j)) ? push_ent_i[j] : ent_d[i];
      end
    end
    count_d = count_q + CNT_W'(push_n_i) - CNT_W'(pop_s);
  end

  // Buffer storage and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign head_o      = ent_q[0];

endmodule

// File: rtl/csi2_tx_rawn_packer.sv
// Packs right-justified pixels into CSI-2 RAW8/10/12/16 payload bytes with a
// small output buffer, per-frame mode latch and line-length checking.
module csi2_tx_rawn_packer
  import csi2_tx_pkg::*;
#(
  parameter int unsigned PIX_WIDTH      = 16,
  parameter int unsigned WORDS_PER_LINE = 256,
  parameter int unsigned BUF_BYTES      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           cfg_mode,
  input  logic [PIX_WIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 line_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(BUF_BYTES + 1);
  localparam int unsigned LEN_W = $clog2(WORDS_PER_LINE + 1);

  raw_mode_t  mode_q, mode_d, eff_mode_s;
  logic [1:0] grp_idx_q, grp_idx_d;
  logic [11:0] g0_q, g0_d;
  logic [9:0] g1_q, g1_d, g2_q, g2_d;
  logic       grp_user_q, grp_user_d;
  logic [LEN_W-1:0] pix_cnt_q, pix_cnt_d;
  logic       line_err_q, line_err_d;
  logic       busy_q, busy_d;

  logic [CNT_W-1:0] count_s, count_nxt_s, free_s;
  logic [2:0] last_idx_s, push_bytes_s, push_n_s;
  logic       complete_s, ready_s, accept_s, pop_s, short_s, len_bad_s;
  logic [15:0] p0_s;
  logic [11:0] p1_s;
  logic [9:0]  p2_s, p3_s;
  buf_ent_t [MAX_GRP_BYTES-1:0] push_ent_s;
  buf_ent_t   head_s;

  // Beat decode: the tuser beat already uses the incoming cfg_mode.
  always_comb begin
    eff_mode_s   = s_axis_tuser ? raw_mode_t'(cfg_mode) : mode_q;
    last_idx_s   = grp_pixels(eff_mode_s) - 3'd1;
    complete_s   = s_axis_tlast || ({1'b0, grp_idx_q} >= last_idx_s);
    short_s      = {1'b0, grp_idx_q} < last_idx_s;
    push_bytes_s = complete_s ? grp_bytes(eff_mode_s) : 3'd0;
    free_s       = CNT_W'(BUF_BYTES) - count_s;
    ready_s      = free_s >= CNT_W'(push_bytes_s);
    accept_s     = s_axis_tvalid && ready_s;
    push_n_s     = accept_s ? push_bytes_s : 3'd0;
    len_bad_s    = pix_cnt_q != LEN_W'(WORDS_PER_LINE - 1);
  end

  // Group pixels: earlier slots from storage, current beat in place, later slots zero-padded.
  always_comb begin
    p0_s = (grp_idx_q == 2'd0) ? s_axis_tdata[15:0] : {4'h0, g0_q};
    p1_s = (grp_idx_q == 2'd1) ? s_axis_tdata[11:0]
         : ((grp_idx_q > 2'd1) ? {2'b00, g1_q} : 12'h000);
    p2_s = (grp_idx_q == 2'd2) ? s_axis_tdata[9:0]
         : ((grp_idx_q == 2'd3) ? g2_q : 10'h000);
    p3_s = (grp_idx_q == 2'd3) ? s_axis_tdata[9:0] : 10'h000;
  end

  // Byte formatting of the completed group plus its sideband flags.
  always_comb begin
    push_ent_s = '0;
    case (eff_mode_s)
      RAW8: begin
        push_ent_s[0].data = p0_s[7:0];
      end
      RAW16: begin
        push_ent_s[0].data = p0_s[7:0];
        push_ent_s[1].data = p0_s[15:8];
      end
      RAW12: begin
        push_ent_s[0].data = p0_s[11:4];
        push_ent_s[1].data = p1_s[11:4];
        push_ent_s[2].data = {p1_s[3:0], p0_s[3:0]};
      end
      RAW10: begin
        push_ent_s[0].data = p0_s[9:2];
        push_ent_s[1].data = p1_s[9:2];
        push_ent_s[2].data = p2_s[9:2];
        push_ent_s[3].data = p3_s[9:2];
        push_ent_s[4].data = {p3_s[1:0], p2_s[1:0], p1_s[1:0], p0_s[1:0]};
      end
      default: begin
        push_ent_s = '0;
      end
    endcase
    push_ent_s[0].user = grp_user_q | s_axis_tuser;
    for (int j = 0; j < int'(MAX_GRP_BYTES); j++) begin
      push_ent_s[j].last = s_axis_tlast && (j == int'(push_bytes_s) - 1);
    end
  end

  // Next-state for mode latch, group storage, line counter and status flags.
  always_comb begin
    mode_d     = mode_q;
    grp_idx_d  = grp_idx_q;
    g0_d       = g0_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    grp_user_d = grp_user_q;
    pix_cnt_d  = pix_cnt_q;
    line_err_d = 1'b0;
    if (accept_s) begin
      mode_d = eff_mode_s;
      if (complete_s) begin
        grp_idx_d  = 2'd0;
        grp_user_d = 1'b0;
      end else begin
        grp_idx_d  = grp_idx_q + 2'd1;
        grp_user_d = grp_user_q | s_axis_tuser;
      end
      case (grp_idx_q)
        2'd0:    g0_d = s_axis_tdata[11:0];
        2'd1:    g1_d = s_axis_tdata[9:0];
        2'd2:    g2_d = s_axis_tdata[9:0];
        default: g0_d = g0_q;
      endcase
      if (s_axis_tlast) begin
        pix_cnt_d  = '0;
        line_err_d = short_s || len_bad_s;
      end else if (pix_cnt_q != LEN_W'(WORDS_PER_LINE)) begin
        // Saturate so an overlong line cannot wrap back to a matching count.
        pix_cnt_d = pix_cnt_q + LEN_W'(1);
      end else begin
        pix_cnt_d = pix_cnt_q;
      end
    end else begin
      line_err_d = 1'b0;
    end
    busy_d = (grp_idx_d != 2'd0) || (count_nxt_s != '0);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= RAW16;
      grp_idx_q  <= 2'd0;
      g0_q       <= 12'h000;
      g1_q       <= 10'h000;
      g2_q       <= 10'h000;
      grp_user_q <= 1'b0;
      pix_cnt_q  <= '0;
      line_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      grp_idx_q  <= grp_idx_d;
      g0_q       <= g0_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      grp_user_q <= grp_user_d;
      pix_cnt_q  <= pix_cnt_d;
      line_err_q <= line_err_d;
      busy_q     <= busy_d;
    end
  end

  csi2_tx_byte_fifo #(
    .BUF_BYTES (BUF_BYTES)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_n_i    (push_n_s),
    .push_ent_i  (push_ent_s),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .count_nxt_o (count_nxt_s),
    .head_o      (head_s)
  );

  assign pop_s         = m_axis_tvalid && m_axis_tready;
  assign s_axis_tready = ready_s;
  assign m_axis_tvalid = (count_s != '0);
  assign m_axis_tdata  = head_s.data;
  assign m_axis_tlast  = head_s.last;
  assign m_axis_tuser  = head_s.user;
  assign line_err      = line_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_csi2_tx_rawn_packer.sv
// Bench for csi2_tx_rawn_packer: directed vectors plus random traffic against a
// queue-based byte model of the RAWn packing rules.
module tb_csi2_tx_rawn_packer;

  localparam int BUF = 8;
  localparam int WPL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cfg_mode = 2'd3;
  logic [15:0] s_axis_tdata = 16'h0000;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        line_err;
  logic        busy;

  csi2_tx_rawn_packer #(
    .PIX_WIDTH      (16),
    .WORDS_PER_LINE (WPL),
    .BUF_BYTES      (BUF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .line_err      (line_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int  pix_m[$];
  int  mode_m = 3;
  bit  user_m = 1'b0;
  int  cnt_m = 0;
  bit  err_exp = 1'b0;
  int  rdy_pct = 100;
  bit  acc_g = 1'b0;
  int  err_seen = 0;
  int  pop_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int px(input int mode);
    case (mode)
      0: return 1;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int nb(input int mode);
    case (mode)
      0: return 1;
      1: return 5;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  // Turn the collected pixels (zero-padded) into expected {user,last,byte} entries.
  function automatic void emit_group(input int mode, input bit usr, input bit lst);
    int p[4];
    int b[5];
    int n;
    n = nb(mode);
    for (int k = 0; k < 4; k++) p[k] = (k < pix_m.size()) ? pix_m[k] : 0;
    for (int k = 0; k < 5; k++) b[k] = 0;
    case (mode)
      0: b[0] = p[0] & 'hFF;
      1: begin
        for (int k = 0; k < 4; k++) b[k] = (p[k] >> 2) & 'hFF;
        b[4] = (p[0] & 3) | ((p[1] & 3) << 2) | ((p[2] & 3) << 4) | ((p[3] & 3) << 6);
      end
      2: begin
        b[0] = (p[0] >> 4) & 'hFF;
        b[1] = (p[1] >> 4) & 'hFF;
        b[2] = (p[0] & 'hF) | ((p[1] & 'hF) << 4);
      end
      default: begin
        b[0] = p[0] & 'hFF;
        b[1] = (p[0] >> 8) & 'hFF;
      end
    endcase
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == 0) && usr, lst && (k == n - 1), 8'(b[k])});
  endfunction

  task automatic cycle();
    int  eff;
    int  n;
    int  pb;
    bit  comp;
    bit  exp_rdy;
    bit  e;
    m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    @(negedge clk);
    chk("line_err", line_err, err_exp);
    if (line_err) err_seen++;
    chk("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
    chk("busy", busy, (pix_m.size() != 0) || (exp_q.size() != 0));
    if (exp_q.size() != 0) chk("head", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q[0]);
    eff     = s_axis_tuser ? int'(cfg_mode) : mode_m;
    n       = px(eff);
    comp    = s_axis_tlast || (pix_m.size() + 1 >= n);
    pb      = comp ? nb(eff) : 0;
    exp_rdy = (BUF - exp_q.size()) >= pb;
    chk("s_tready", s_axis_tready, exp_rdy);
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      pop_cnt++;
    end
    if ((exp_q.size() != 0) && m_axis_tready) void'(exp_q.pop_front());
    e = 1'b0;
    if (s_axis_tvalid && exp_rdy) begin
      acc_g = 1'b1;
      if (s_axis_tuser) mode_m = int'(cfg_mode);
      user_m = user_m | s_axis_tuser;
      pix_m.push_back(int'(s_axis_tdata));
      if (comp) begin
        e = s_axis_tlast && ((pix_m.size() != n) || (cnt_m + 1 != WPL));
        emit_group(mode_m, user_m, s_axis_tlast);
        pix_m.delete();
        user_m = 1'b0;
      end
      cnt_m = s_axis_tlast ? 0 : cnt_m + 1;
    end
    err_exp = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input bit u, input bit l, input logic [1:0] m);
    int k;
    k = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    cfg_mode      = m;
    s_axis_tvalid = 1'b1;
    acc_g         = 1'b0;
    while (!acc_g && k < 500) begin
      cycle();
      k++;
    end
    if (!acc_g) chk("accept_timeout", 32'd0, 32'd1);
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    cycle();
    cycle();
    while (exp_q.size() != 0 && k < 2000) begin
      cycle();
      k++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tuser  = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    pix_m.delete();
    mode_m  = 3;
    user_m  = 1'b0;
    cnt_m   = 0;
    err_exp = 1'b0;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tuser", m_axis_tuser, 0);
    chk("rst_line_err", line_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_tready", s_axis_tready, 1);
  endtask

  task automatic check_log(input string tag, input logic [9:0] e[$]);
    chk({tag, "_len"}, got_q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      if (i < got_q.size()) chk(tag, got_q[i], e[i]);
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) begin
      s_axis_tvalid = 1'b0;
      cycle();
    end
  endtask

  initial begin
    logic [9:0] ev[$];
    int e0;
    int p0;
    int len;
    int md;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    rdy_pct = 100;

    // RAW16 single pixel line, first byte one cycle after acceptance
    got_q.delete();
    send(16'hA55A, 1'b1, 1'b1, 2'd3);
    chk("raw16_latency_valid", m_axis_tvalid, 1);
    chk("raw16_latency_data", m_axis_tdata, 8'h5A);
    drain();
    ev = '{10'h25A, 10'h1A5};
    check_log("raw16", ev);

    // RAW10 full group, exact line length
    got_q.delete();
    e0 = err_seen;
    send(16'h03FF, 1'b1, 1'b0, 2'd1);
    send(16'h0000, 1'b0, 1'b0, 2'd1);
    send(16'h0155, 1'b0, 1'b0, 2'd1);
    send(16'h02AA, 1'b0, 1'b1, 2'd1);
    drain();
    ev = '{10'h2FF, 10'h000, 10'h055, 10'h0AA, 10'h193};
    check_log("raw10", ev);
    chk("raw10_no_err", err_seen - e0, 0);

    // RAW12 pair
    got_q.delete();
    send(16'h0ABC, 1'b1, 1'b0, 2'd2);
    send(16'h0123, 1'b0, 1'b1, 2'd2);
    drain();
    ev = '{10'h2AB, 10'h012, 10'h13C};
    check_log("raw12", ev);

    // RAW10 short group, padded, one error pulse
    got_q.delete();
    e0 = err_seen;
    send(16'h0004, 1'b1, 1'b0, 2'd1);
    send(16'h0008, 1'b0, 1'b0, 2'd1);
    send(16'h000C, 1'b0, 1'b1, 2'd1);
    drain();
    ev = '{10'h201, 10'h002, 10'h003, 10'h000, 10'h100};
    check_log("raw10_short", ev);
    chk("raw10_short_err", err_seen - e0, 1);

    // Mode only changes on a tuser beat
    got_q.delete();
    send(16'h1234, 1'b1, 1'b0, 2'd3);
    send(16'h5678, 1'b0, 1'b1, 2'd0);
    send(16'h9ABC, 1'b1, 1'b1, 2'd0);
    drain();
    ev = '{10'h234, 10'h012, 10'h078, 10'h156, 10'h3BC};
    check_log("mode_switch", ev);

    // Reset with buffered bytes and a partial group
    rdy_pct = 0;
    send(16'h0111, 1'b1, 1'b0, 2'd1);
    send(16'h0222, 1'b0, 1'b0, 2'd1);
    send(16'h0333, 1'b0, 1'b0, 2'd1);
    send(16'h0044, 1'b0, 1'b0, 2'd1);
    send(16'h0155, 1'b0, 1'b0, 2'd1);
    do_reset();
    rdy_pct = 100;
    got_q.delete();
    send(16'hBEEF, 1'b1, 1'b0, 2'd3);
    send(16'h0102, 1'b0, 1'b1, 2'd3);
    drain();
    ev = '{10'h2EF, 10'h0BE, 10'h002, 10'h101};
    check_log("after_reset", ev);

    // Random frames with back-pressure
    rdy_pct = 50;
    for (int f = 0; f < 8; f++) begin
      md = $urandom_range(0, 3);
      for (int ln = 0; ln < 3; ln++) begin
        len = $urandom_range(1, 9);
        for (int p = 0; p < len; p++) begin
          gap();
          send(16'($urandom), (ln == 0) && (p == 0), p == len - 1,
               ((ln == 0) && (p == 0)) ? 2'(md) : 2'($urandom_range(0, 3)));
        end
      end
    end
    drain();

    // Full 256-pixel RAW10 line yields 320 bytes
    p0 = pop_cnt;
    for (int p = 0; p < 256; p++) begin
      gap();
      send(16'($urandom), p == 0, p == 255, 2'd1);
    end
    drain();
    chk("raw10_256_bytes", pop_cnt - p0, 320);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
